// File: rtl/scc_wave_scheduler.sv
// SCC wave scheduler: time-multiplexes one wave RAM port between five tone
// channels (slots 0..4) and a CPU bus slot (slot 5). Each channel fetch is
// returned as a registered sample; CPU accesses are parked until slot 5.
module scc_wave_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       scc_plus,
    output logic [2:0] active,
    output logic       gen_enable,
    input  logic [4:0] wave_address,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    input  logic       bus_req,
    input  logic       bus_wr,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic       bus_ack,
    output logic [7:0] bus_rdata,
    output logic       sample_valid,
    output logic [2:0] sample_ch,
    output logic [7:0] sample
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_DONE    = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5
    } bus_state_t;

    localparam logic [2:0] BUS_SLOT = 3'd5;

    // Address lies inside the 160-byte wave RAM.
    function automatic logic addr_in_ram(input logic [7:0] addr);
        return (addr < 8'd160);
    endfunction

    // Writes to the 128..159 region are only honoured in SCC+ mode.
    function automatic logic write_allowed(input logic [7:0] addr, input logic plus);
        return addr_in_ram(addr) && (plus || (addr < 8'd128));
    endfunction

    logic [2:0]  r_slot;
    bus_state_t  r_state;
    bus_state_t  w_next_state;
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_bus_rdata;
    logic        r_pend;
    logic [2:0]  r_pend_ch;
    logic        r_sample_valid;
    logic [2:0]  r_sample_ch;
    logic [7:0]  r_sample;
    logic [7:0]  w_chan_base;
    logic [7:0]  w_chan_addr;

    assign active       = r_slot;
    assign gen_enable   = clk_en;
    assign bus_ack      = (r_state == S_ACK);
    assign bus_rdata    = r_bus_rdata;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign sample       = r_sample;

    // Slot counter: advances 0..5 and wraps on each clk_en strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= 3'd0;
        end else if (clk_en) begin
            r_slot <= (r_slot == BUS_SLOT) ? 3'd0 : (r_slot + 3'd1);
        end else begin
            r_slot <= r_slot;
        end
    end

    // Per-channel table base; channel E shares channel D's table outside SCC+ mode.
    always_comb begin
        w_chan_base = 8'd0;
        case (r_slot)
            3'd0:    w_chan_base = 8'd0;
            3'd1:    w_chan_base = 8'd32;
            3'd2:    w_chan_base = 8'd64;
            3'd3:    w_chan_base = 8'd96;
            3'd4:    w_chan_base = scc_plus ? 8'd128 : 8'd96;
            default: w_chan_base = 8'd0;
        endcase
        w_chan_addr = w_chan_base + {3'b000, wave_address};
    end

    // RAM port mux: the CPU owns the port only in ACCESS; write strobe never leaves ACCESS.
    always_comb begin
        ram_addr  = 8'd0;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (r_state == S_ACCESS) begin
            ram_addr = r_addr;
            if (r_wr && write_allowed(r_addr, scc_plus)) begin
                ram_we    = 1'b1;
                ram_wdata = r_wdata;
            end else begin
                ram_we    = 1'b0;
                ram_wdata = 8'd0;
            end
        end else if (r_slot != BUS_SLOT) begin
            ram_addr = w_chan_addr;
        end else begin
            ram_addr = 8'd0;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus FSM next-state: one RAM access per request, served in the bus slot.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    w_next_state = bus_req ? S_WAIT : S_IDLE;
            S_WAIT:    w_next_state = (r_slot == BUS_SLOT) ? S_ACCESS : S_WAIT;
            S_ACCESS:  w_next_state = S_DONE;
            S_DONE:    w_next_state = S_ACK;
            S_ACK:     w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = bus_req ? S_RELEASE : S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Latch the CPU request when it is accepted out of IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
        end else if ((r_state == S_IDLE) && bus_req) begin
            r_wr    <= bus_wr;
            r_addr  <= bus_addr;
            r_wdata <= bus_wdata;
        end else begin
            r_wr    <= r_wr;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Read result: RAM data arrives in DONE; out-of-range reads return all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_rdata <= 8'h00;
        end else if ((r_state == S_DONE) && !r_wr) begin
            r_bus_rdata <= addr_in_ram(r_addr) ? ram_rdata : 8'hFF;
        end else begin
            r_bus_rdata <= r_bus_rdata;
        end
    end

    // Remember which channel slot just ended; its RAM data is on ram_rdata next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_pend_ch <= 3'd0;
        end else if (clk_en && (r_slot != BUS_SLOT)) begin
            r_pend    <= 1'b1;
            r_pend_ch <= r_slot;
        end else begin
            r_pend    <= 1'b0;
            r_pend_ch <= r_pend_ch;
        end
    end

    // Capture the fetched sample and present it as a one-cycle pulse; data holds afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_valid <= 1'b0;
            r_sample_ch    <= 3'd0;
            r_sample       <= 8'h00;
        end else if (r_pend) begin
            r_sample_valid <= 1'b1;
            r_sample_ch    <= r_pend_ch;
            r_sample       <= ram_rdata;
        end else begin
            r_sample_valid <= 1'b0;
            r_sample_ch    <= r_sample_ch;
            r_sample       <= r_sample;
        end
    end

endmodule

// File: tb/tb_scc_wave_scheduler.sv
// Directed bench for scc_wave_scheduler with a behavioural synchronous wave RAM.
module tb_scc_wave_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       scc_plus = 1'b1;
    logic [2:0] active;
    logic       gen_enable;
    logic [4:0] wave_address = 5'd0;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic       bus_req = 1'b0;
    logic       bus_wr = 1'b0;
    logic [7:0] bus_addr = 8'h00;
    logic [7:0] bus_wdata = 8'h00;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       sample_valid;
    logic [2:0] sample_ch;
    logic [7:0] sample;

    scc_wave_scheduler dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .scc_plus(scc_plus),
        .active(active), .gen_enable(gen_enable), .wave_address(wave_address),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample(sample)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Wave RAM model and its initial contents.
    logic [7:0] mem [0:159];

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    // Synchronous RAM: registered read of the presented address, write on ram_we.
    always @(posedge clk) begin
        ram_rdata <= (ram_addr < 8'd160) ? mem[ram_addr] : 8'h00;
        if (ram_we && (ram_addr < 8'd160)) mem[ram_addr] = ram_wdata;
    end

    // Monitors sampled on the falling edge.
    int cyc = 0;
    int we_cnt = 0;
    int we_time = 0;
    int ack_cnt = 0;
    int ack_time = 0;
    logic [2:0] we_slot = 3'd0;
    logic [10:0] sq[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (sample_valid) sq.push_back({sample_ch, sample});
            if (ram_we) begin
                we_cnt  = we_cnt + 1;
                we_slot = active;
                we_time = cyc;
            end
            if (bus_ack) begin
                ack_cnt  = ack_cnt + 1;
                ack_time = cyc;
            end
        end
    end

    // Optional free-running clk_en generator.
    logic ce_auto = 1'b0;
    int   ce_period = 4;
    int   ce_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ce_auto) begin
                ce_cnt = ce_cnt + 1;
                clk_en = ((ce_cnt % ce_period) == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xact(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input int hold, output logic got, output logic [7:0] rd,
                            output int lat);
        got = 1'b0;
        rd  = 8'h00;
        lat = 0;
        bus_wr = wr; bus_addr = a; bus_wdata = d; bus_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            lat = i + 1;
            if (bus_ack) begin
                got = 1'b1;
                rd  = bus_rdata;
                break;
            end
        end
        for (int i = 0; i < hold; i++) step();
        bus_req = 1'b0;
        repeat (3) step();
    endtask

    typedef struct {
        logic       plus;
        logic [4:0] wa;
        logic [2:0] exp_active;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic       got;
        logic [7:0] rd;
        int         lat;
        int         n;
        int         bad;
        logic [2:0] prev_ch;

        tbl[0]  = '{1'b1, 5'd5, 3'd0, 8'd5};
        tbl[1]  = '{1'b1, 5'd5, 3'd1, 8'd37};
        tbl[2]  = '{1'b1, 5'd5, 3'd2, 8'd69};
        tbl[3]  = '{1'b1, 5'd5, 3'd3, 8'd101};
        tbl[4]  = '{1'b1, 5'd5, 3'd4, 8'd133};
        tbl[5]  = '{1'b1, 5'd5, 3'd5, 8'd0};
        tbl[6]  = '{1'b0, 5'd7, 3'd0, 8'd7};
        tbl[7]  = '{1'b0, 5'd7, 3'd1, 8'd39};
        tbl[8]  = '{1'b0, 5'd7, 3'd2, 8'd71};
        tbl[9]  = '{1'b0, 5'd7, 3'd3, 8'd103};
        tbl[10] = '{1'b0, 5'd7, 3'd4, 8'd103};
        tbl[11] = '{1'b0, 5'd7, 3'd5, 8'd0};

        for (int i = 0; i < 160; i++) mem[i] = init_val(i);

        // Reset state
        repeat (2) step();
        check("rst_active", 32'(active), 32'd0);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_rdata", 32'(bus_rdata), 32'h00);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_sample", 32'(sample), 32'h00);
        check("rst_ch", 32'(sample_ch), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        reset = 1'b0;
        step();
        sq.delete();

        // Slot walk: clk_en every 4 cycles, address per slot and mode
        for (int r = 0; r < 12; r++) begin
            scc_plus     = tbl[r].plus;
            wave_address = tbl[r].wa;
            #1;
            check($sformatf("active_%0d", r), 32'(active), 32'(tbl[r].exp_active));
            check($sformatf("ram_addr_%0d", r), 32'(ram_addr), 32'(tbl[r].exp_addr));
            check($sformatf("gen_en_%0d", r), 32'(gen_enable), 32'd0);
            if (r < 11) begin
                clk_en = 1'b1;
                #1;
                check($sformatf("gen_en_hi_%0d", r), 32'(gen_enable), 32'd1);
                step();
                clk_en = 1'b0;
                repeat (3) step();
            end
        end
        repeat (3) step();

        // One sample per channel slot, none for the bus slot
        check("sample_count", 32'(sq.size()), 32'd10);
        n = 0;
        for (int r = 0; r < 12; r++) begin
            if (tbl[r].exp_active != 3'd5) begin
                if (n < sq.size()) begin
                    check($sformatf("sample_ch_%0d", r), 32'(sq[n][10:8]), 32'(tbl[r].exp_active));
                    check($sformatf("sample_val_%0d", r), 32'(sq[n][7:0]),
                          32'(init_val(int'(tbl[r].exp_addr))));
                end
                n = n + 1;
            end
        end
        check("sample_hold", 32'(sample), 32'(init_val(103)));

        // scc_plus=0: write into channel E region is acknowledged but not performed
        we_cnt = 0; ack_cnt = 0;
        ce_period = 4; ce_cnt = 0; ce_auto = 1'b1;
        bus_xact(1'b1, 8'd130, 8'h3C, 0, got, rd, lat);
        check("w130_ack", 32'(got), 32'd1);
        check("w130_no_we", 32'(we_cnt), 32'd0);
        check("w130_mem", 32'(mem[130]), 32'(init_val(130)));

        // Write raised in slot 1 waits for slot 5, single strobe, ack two cycles later
        scc_plus = 1'b1;
        n = 0;
        while (active != 3'd1 && n < 100) begin step(); n = n + 1; end
        check("reach_slot1", 32'(active), 32'd1);
        we_cnt = 0; ack_cnt = 0;
        bus_xact(1'b1, 8'd40, 8'hA5, 0, got, rd, lat);
        check("w40_ack", 32'(got), 32'd1);
        check("w40_latency", 32'(lat <= 27), 32'd1);
        check("w40_we_cnt", 32'(we_cnt), 32'd1);
        check("w40_we_slot", 32'(we_slot), 32'd5);
        check("w40_ack_delay", 32'(ack_time - we_time), 32'd2);
        check("w40_ack_cnt", 32'(ack_cnt), 32'd1);
        check("w40_mem", 32'(mem[40]), 32'hA5);
        bus_xact(1'b0, 8'd40, 8'h00, 0, got, rd, lat);
        check("r40_ack", 32'(got), 32'd1);
        check("r40_data", 32'(rd), 32'hA5);

        // Out-of-range read and a request held long after the ack
        we_cnt = 0; ack_cnt = 0;
        bus_xact(1'b0, 8'd200, 8'h00, 10, got, rd, lat);
        check("r200_ack", 32'(got), 32'd1);
        check("r200_data", 32'(rd), 32'hFF);
        check("r200_single_ack", 32'(ack_cnt), 32'd1);
        check("r200_no_we", 32'(we_cnt), 32'd0);

        // clk_en every cycle: access still served, sample sequence uninterrupted
        ce_period = 1; ce_cnt = 0;
        repeat (2) step();
        sq.delete();
        we_cnt = 0; ack_cnt = 0;
        bus_xact(1'b1, 8'd50, 8'h77, 0, got, rd, lat);
        repeat (12) step();
        check("fast_ack", 32'(got), 32'd1);
        check("fast_ack_cnt", 32'(ack_cnt), 32'd1);
        check("fast_we_cnt", 32'(we_cnt), 32'd1);
        check("fast_mem", 32'(mem[50]), 32'h77);
        check("fast_samples", 32'(sq.size() >= 10), 32'd1);
        bad = 0;
        if (sq.size() > 0) prev_ch = sq[0][10:8];
        for (int i = 1; i < sq.size(); i++) begin
            if (sq[i][10:8] != ((prev_ch == 3'd4) ? 3'd0 : prev_ch + 3'd1)) bad = bad + 1;
            prev_ch = sq[i][10:8];
        end
        check("fast_seq", 32'(bad), 32'd0);

        // Reset during ACCESS aborts the transaction
        ce_period = 4; ce_cnt = 0;
        repeat (4) step();
        we_cnt = 0; ack_cnt = 0;
        bus_wr = 1'b1; bus_addr = 8'd60; bus_wdata = 8'h11; bus_req = 1'b1;
        n = 0;
        while (!ram_we && n < 60) begin step(); n = n + 1; end
        check("abort_reach_access", 32'(ram_we), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_we_low", 32'(ram_we), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        bus_req = 1'b0;
        ce_auto = 1'b0;
        clk_en = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("abort_active_rel", 32'(active), 32'd0);
        repeat (10) step();
        check("abort_no_ack", 32'(ack_cnt), 32'd0);
        check("abort_mem", 32'(mem[60]), 32'(init_val(60)));
        clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        check("first_ce_slot1", 32'(active), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
